// File: rtl/mua_decode_fifo.sv
// Decode-at-push instruction queue between the RX stage and the ALU.
// Each entry holds the decoded control word, routed operands and illegal flag.
package mua_pkg;
  typedef struct packed {
    logic       pre_x_en;
    logic       pre_x_sub;
    logic       pre_y_en;
    logic       pre_y_sub;
    logic       mul_x_en;
    logic       mul_y_en;
    logic [2:0] mul_x_sel;
    logic [2:0] mul_y_sel;
    logic       post_en;
    logic       post_sub;
  } alu_ctrl_t;
endpackage

module mua_decode_fifo
  import mua_pkg::*;
#(
  parameter int W        = 8,
  parameter int DEPTH    = 2,
  parameter bit DET_SWAP = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 op,
  input  logic [W-1:0]               a1,
  input  logic [W-1:0]               a2,
  input  logic [W-1:0]               b1,
  input  logic [W-1:0]               b2,
  output logic                       out_valid,
  input  logic                       out_ready,
  output alu_ctrl_t                  ctrl,
  output logic [W-1:0]               x0,
  output logic [W-1:0]               x1,
  output logic [W-1:0]               y0,
  output logic [W-1:0]               y1,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [7:0]                 err_cnt
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    alu_ctrl_t    ctrl;
    logic         ill;
    logic [W-1:0] x0;
    logic [W-1:0] x1;
    logic [W-1:0] y0;
    logic [W-1:0] y1;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  entry_t          dec;
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic            push;
  logic            pop;
  logic            swap;

  assign in_ready  = !rst && (count < FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign swap      = DET_SWAP && (op == 8'h09);

  always_comb begin
    dec           = '0;
    dec.ctrl.mul_x_sel = 3'd1;
    dec.ctrl.mul_y_sel = 3'd1;
    dec.ill       = 1'b0;
    dec.x0        = a1;
    dec.x1        = swap ? b2 : a2;
    dec.y0        = b1;
    dec.y1        = swap ? a2 : b2;
    unique case (op) inside
      8'h00: ;
      [8'h01:8'h05]: begin
        dec.ctrl.mul_x_en = 1'b1;
        dec.ctrl.mul_y_en = 1'b1;
        dec.ctrl.post_en  = 1'b1;
      end
      8'h06, 8'h07: begin
        dec.ctrl.pre_x_en  = 1'b1;
        dec.ctrl.pre_y_en  = 1'b1;
        dec.ctrl.pre_x_sub = op[0];
        dec.ctrl.pre_y_sub = op[0];
        dec.ctrl.mul_x_en  = 1'b1;
        dec.ctrl.mul_y_en  = 1'b1;
        dec.ctrl.mul_x_sel = 3'd4;
        dec.ctrl.mul_y_sel = 3'd4;
      end
      [8'h08:8'h0A]: begin
        dec.ctrl.mul_x_en = 1'b1;
        dec.ctrl.mul_y_en = 1'b1;
        dec.ctrl.post_en  = 1'b1;
        dec.ctrl.post_sub = 1'b1;
      end
      8'h0B: begin
        dec.ctrl.pre_x_en  = 1'b1;
        dec.ctrl.pre_x_sub = 1'b1;
        dec.ctrl.pre_y_en  = 1'b1;
        dec.ctrl.pre_y_sub = 1'b1;
        dec.ctrl.mul_x_en  = 1'b1;
        dec.ctrl.mul_y_en  = 1'b1;
        dec.ctrl.mul_x_sel = 3'd2;
        dec.ctrl.mul_y_sel = 3'd2;
        dec.ctrl.post_en   = 1'b1;
        dec.ctrl.post_sub  = 1'b1;
      end
      8'h0C: begin
        dec.ctrl.pre_x_en = 1'b1;
        dec.ctrl.post_en  = 1'b1;
      end
      8'h0D: begin
        dec.ctrl.mul_x_en = 1'b1;
        dec.ctrl.mul_y_en = 1'b1;
      end
      8'h0E: begin
        dec.ctrl.mul_x_en  = 1'b1;
        dec.ctrl.mul_x_sel = 3'd4;
        dec.ctrl.pre_y_en  = 1'b1;
        dec.ctrl.pre_y_sub = 1'b1;
        dec.ctrl.mul_y_en  = 1'b1;
        dec.ctrl.mul_y_sel = 3'd3;
        dec.ctrl.post_en   = 1'b1;
      end
      8'h0F: begin
        dec.ctrl.pre_x_en  = 1'b1;
        dec.ctrl.pre_x_sub = 1'b1;
        dec.ctrl.mul_x_en  = 1'b1;
        dec.ctrl.mul_x_sel = 3'd3;
        dec.ctrl.mul_y_en  = 1'b1;
        dec.ctrl.mul_y_sel = 3'd4;
        dec.ctrl.post_en   = 1'b1;
      end
      default: dec.ill = 1'b1;
    endcase
  end

  // Payload storage is never reset; validity comes from count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= dec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      err_cnt <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (push && dec.ill && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 1'b1;
    end
  end

  assign head        = out_valid ? mem[rptr] : '0;
  assign ctrl        = head.ctrl;
  assign x0          = head.x0;
  assign x1          = head.x1;
  assign y0          = head.y0;
  assign y1          = head.y1;
  assign out_illegal = head.ill;

endmodule

// File: tb/tb_mua_decode_fifo.sv
// Directed bench for mua_decode_fifo: decode table, backpressure,
// wrap, illegal saturation, DET2 swap and mid-stream reset.
module tb_mua_decode_fifo;
  import mua_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] op;
  logic [7:0] a1, a2, b1, b2;
  logic       out_valid;
  logic       out_ready;
  alu_ctrl_t  ctrl;
  logic [7:0] x0, x1, y0, y1;
  logic       out_illegal;
  logic [1:0] count;
  logic [7:0] err_cnt;

  logic       s_in_ready, s_out_valid, s_ill;
  alu_ctrl_t  s_ctrl;
  logic [7:0] s_x0, s_x1, s_y0, s_y1, s_err;
  logic [1:0] s_count;

  int tests = 0;
  int fails = 0;
  int err_exp = 0;

  always #5 clk = ~clk;

  mua_decode_fifo #(.W(8), .DEPTH(2), .DET_SWAP(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a1(a1), .a2(a2), .b1(b1), .b2(b2),
    .out_valid(out_valid), .out_ready(out_ready), .ctrl(ctrl),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .out_illegal(out_illegal),
    .count(count), .err_cnt(err_cnt)
  );

  mua_decode_fifo #(.W(8), .DEPTH(2), .DET_SWAP(1)) sdut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .op(op), .a1(a1), .a2(a2), .b1(b1), .b2(b2),
    .out_valid(s_out_valid), .out_ready(out_ready), .ctrl(s_ctrl),
    .x0(s_x0), .x1(s_x1), .y0(s_y0), .y1(s_y1), .out_illegal(s_ill),
    .count(s_count), .err_cnt(s_err)
  );

  typedef struct {
    logic [7:0] op;
    logic [7:0] a1, a2, b1, b2;
    logic [13:0] ctrl;
    logic       ill;
  } vec_t;

  // bits: pxe pxs pye pys mxe mye xsel[3] ysel[3] pe ps
  function automatic logic [13:0] mk(input logic [3:0] pre, input logic [1:0] mul,
                                     input logic [2:0] xs, input logic [2:0] ys,
                                     input logic [1:0] post);
    return {pre, mul, xs, ys, post};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vt[14];

  initial begin
    vt[0]  = '{8'h0B, 5, 2, 7, 3, mk(4'b1111, 2'b11, 2, 2, 2'b11), 0};
    vt[1]  = '{8'h00, 9, 8, 7, 6, mk(4'b0000, 2'b00, 1, 1, 2'b00), 0};
    vt[2]  = '{8'h01, 1, 2, 3, 4, mk(4'b0000, 2'b11, 1, 1, 2'b10), 0};
    vt[3]  = '{8'h05, 8'hFF, 0, 8'hAA, 8'h55, mk(4'b0000, 2'b11, 1, 1, 2'b10), 0};
    vt[4]  = '{8'h06, 3, 4, 5, 6, mk(4'b1010, 2'b11, 4, 4, 2'b00), 0};
    vt[5]  = '{8'h07, 3, 4, 5, 6, mk(4'b1111, 2'b11, 4, 4, 2'b00), 0};
    vt[6]  = '{8'h09, 1, 2, 3, 4, mk(4'b0000, 2'b11, 1, 1, 2'b11), 0};
    vt[7]  = '{8'h0C, 1, 1, 1, 1, mk(4'b1000, 2'b00, 1, 1, 2'b10), 0};
    vt[8]  = '{8'h0D, 2, 2, 2, 2, mk(4'b0000, 2'b11, 1, 1, 2'b00), 0};
    vt[9]  = '{8'h0E, 7, 6, 5, 4, mk(4'b0011, 2'b11, 4, 3, 2'b10), 0};
    vt[10] = '{8'h0F, 7, 6, 5, 4, mk(4'b1100, 2'b11, 3, 4, 2'b10), 0};
    vt[11] = '{8'h10, 1, 2, 3, 4, mk(4'b0000, 2'b00, 1, 1, 2'b00), 1};
    vt[12] = '{8'hFF, 4, 3, 2, 1, mk(4'b0000, 2'b00, 1, 1, 2'b00), 1};
    vt[13] = '{8'h0A, 8'h80, 1, 8'h7F, 0, mk(4'b0000, 2'b11, 1, 1, 2'b11), 0};

    rst = 1; in_valid = 0; out_ready = 0;
    op = 0; a1 = 0; a2 = 0; b1 = 0; b2 = 0;
    step(); step();
    chk("rst_in_ready", in_ready, 0);
    rst = 0;
    step();
    chk("idle_valid", out_valid, 0);
    chk("idle_ready", in_ready, 1);
    chk("idle_count", count, 0);
    chk("idle_ctrl", ctrl, 0);
    chk("idle_x0", x0, 0);
    chk("idle_err", err_cnt, 0);

    foreach (vt[i]) begin
      op = vt[i].op; a1 = vt[i].a1; a2 = vt[i].a2;
      b1 = vt[i].b1; b2 = vt[i].b2;
      in_valid = 1; out_ready = 1;
      step();
      in_valid = 0;
      if (vt[i].ill) err_exp++;
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_ctrl", i), ctrl, vt[i].ctrl);
      chk($sformatf("v%0d_ill", i), out_illegal, vt[i].ill);
      chk($sformatf("v%0d_ops", i), {x0, x1, y0, y1},
          {vt[i].a1, vt[i].a2, vt[i].b1, vt[i].b2});
      step();
      chk($sformatf("v%0d_cnt", i), count, 0);
      chk($sformatf("v%0d_empty_ctrl", i), ctrl, 0);
      chk($sformatf("v%0d_err", i), err_cnt, err_exp);
    end

    // fill with backpressure
    out_ready = 0; op = 8'h01; in_valid = 1;
    for (int k = 0; k < 3; k++) begin
      a1 = 8'd10 + 8'(k);
      step();
    end
    in_valid = 0;
    chk("full_count", count, 2);
    chk("full_ready", in_ready, 0);
    chk("full_head", x0, 10);
    out_ready = 1;
    #1;
    chk("full_ready_nocomb", in_ready, 0);
    step();
    chk("drain1", x0, 11);
    chk("drain1_cnt", count, 1);
    step();
    chk("drain_empty", out_valid, 0);
    chk("drain_cnt", count, 0);

    // simultaneous push/pop across pointer wrap
    out_ready = 0; in_valid = 1; a1 = 20;
    step();
    chk("sim_pre_cnt", count, 1);
    out_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      a1 = 8'd20 + 8'(k);
      step();
      chk($sformatf("sim%0d_cnt", k), count, 1);
      chk($sformatf("sim%0d_head", k), x0, 20 + k);
    end
    in_valid = 0;
    step();
    chk("sim_empty", out_valid, 0);

    // illegal flood, err_cnt saturates
    op = 8'h42; in_valid = 1; out_ready = 1;
    for (int k = 0; k < 300; k++) begin
      step();
      chk("ill_flag", {out_valid, out_illegal}, 2'b11);
    end
    in_valid = 0;
    step();
    chk("err_sat", err_cnt, 255);
    chk("ill_empty", out_valid, 0);

    // DET2 routing, swapped vs default instance
    op = 8'h09; a1 = 1; a2 = 2; b1 = 3; b2 = 4; in_valid = 1;
    step();
    in_valid = 0;
    chk("swap_valid", s_out_valid, 1);
    chk("swap_ops", {s_x0, s_x1, s_y0, s_y1}, {8'd1, 8'd4, 8'd3, 8'd2});
    chk("noswap_ops", {x0, x1, y0, y1}, {8'd1, 8'd2, 8'd3, 8'd4});
    op = 8'h08; in_valid = 1;
    step();
    in_valid = 0;
    chk("swap_only_09", {s_x1, s_y1}, {8'd2, 8'd4});
    step();

    // reset mid-stream
    out_ready = 0; op = 8'h01; in_valid = 1;
    step(); step();
    in_valid = 0;
    chk("pre_rst_cnt", count, 2);
    rst = 1;
    step();
    rst = 0;
    chk("rst_cnt", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_ctrl", ctrl, 0);
    step();
    chk("post_rst_ready", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
